slave_response_sequencer: RTL and testbench
===========================================

Name: slave_response_sequencer

Overview:
Slave-end counterpart of the per-master command sequencer. One instance sits at each slave port. It records, in issue order, which master sent each read command to slave SLAVE_N. It then pairs each slave read response with that master and tags the response with the 7-bit token {master[1:0], slave[1:0], seq[2:0]}. The master side compares this token against its expected next token and accepts the response with resp_accept.

Parameters:
DATA_WIDTH, 32, width of slave read data
SLAVE_N, 0, 2-bit index of the slave this instance serves (0..3)
ORDER_FIFO_EXP, 3, log2 depth of the master-ID order FIFO (depth 8)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset; asynchronous, active-low
cmd_ack  input  1  slave accepted a command; level, edge-detected internally
cmd_rw  input  1  command type of accepted command: 0 = read (tracked), 1 = write (ignored)
cmd_master  input  2  index of the master that issued the accepted command
order_full  output  1  order FIFO full; slave port must not ack further reads
slave_resp_valid  input  1  slave read data valid
slave_resp_data  input  DATA_WIDTH  slave read data
slave_resp_ready  output  1  sequencer can take slave data this cycle
resp_valid  output  1  tagged response presented to masters
resp_data  output  DATA_WIDTH  response data
resp_tag  output  7  {master, SLAVE_N[1:0], seq}
resp_accept  input  1  addressed master consumed the response (equivalent of data_accept)
seq_err  output  1  sticky orphan-response flag (only with optional feature)

Behaviour:
- Reset (rst=0, async) clears all state:
  - FSM = IDLE; order FIFO empty; all four seq counters = 0; ack delay flop = 0.
  - Outputs: resp_valid=0, resp_data=0, resp_tag=0, slave_resp_ready=0, order_full=0, seq_err=0.
- Capture:
  - Push occurs on the cycle where cmd_ack=1, ack_d1=0, cmd_rw=0 and !order_full. It pushes cmd_master into the order FIFO.
  - A held cmd_ack pushes exactly once.
  - A rising edge while full is dropped; the slave port must prevent this by honouring order_full.
- order_full and empty are registered FIFO status. Push and pop in the same cycle are legal: count is unchanged and data order is preserved.
- FSM:
  - IDLE: if FIFO not empty, go to WAIT_DATA next cycle.
  - WAIT_DATA:
    - slave_resp_ready=1 (combinational on state).
    - On slave_resp_valid: register data into resp_data, and resp_tag={fifo head, SLAVE_N, seq[head]}.
    - resp_valid=1 from the next cycle; go to PRESENT.
  - PRESENT:
    - slave_resp_ready=0; resp_valid, resp_data and resp_tag held stable.
    - On resp_accept: pop the FIFO, seq[head] <= seq[head]+1 (3-bit, wraps 7->0), resp_valid=0 next cycle.
    - Then go to WAIT_DATA if FIFO count after the pop is nonzero, else IDLE.
- Latency: slave data to resp_valid is 1 cycle. Accept to next slave_resp_ready is 1 cycle.
- Throughput: one response per 2 cycles minimum.
- Seq counters track deliveries per master to this slave, so token seq equals the master side's per-slave command count.
- resp_accept outside PRESENT is ignored. slave_resp_valid outside WAIT_DATA is not consumed (ready=0).
- Reset mid-PRESENT discards the pending response and all queued order entries.

Optional Feature:
Macro SEQ_ORPHAN_CHECK_EN.
- Defined:
  - In IDLE with FIFO empty, slave_resp_ready=1.
  - Any slave_resp_valid there is consumed and discarded.
  - seq_err sets to 1 and stays set until reset.
- Not defined:
  - seq_err is tied to 0.
  - slave_resp_ready=0 in IDLE, so an orphan response stalls at the slave.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, FSM IDLE, slave_resp_ready=0.
- SLAVE_N=2. Read from master 1, then slave data 0xA5A5A5A5 -> resp_valid next cycle, resp_tag=7'b01_10_000. Hold resp_accept=0 for 3 cycles -> outputs stable. Pulse accept -> resp_valid=0.
- Reads from masters 3, 0, 3 in order, then three slave responses each accepted immediately -> tags 11_xx_000, 00_xx_000, 11_xx_001 in that order.
- cmd_ack held high 4 cycles with cmd_rw=0 -> one FIFO entry. cmd_rw=1 edge -> no entry; no response expected.
- 8 reads queued -> order_full=1. Accept one response -> order_full=0. Simultaneous push and accept -> count unchanged.
- 9 sequential reads from master 2 -> 9th tag seq wraps to 000. With SEQ_ORPHAN_CHECK_EN: slave data with FIFO empty -> consumed, seq_err=1 and stays 1.

Source files
------------

// File: rtl/slave_response_sequencer.sv
// Slave-side response sequencer: records the issuing master of each read in order, then tags each slave read response with {master, slave, seq}.
// Optional macro SEQ_ORPHAN_CHECK_EN: swallow responses that arrive with no outstanding read and raise sticky seq_err.
module slave_response_sequencer #(
   parameter int          DATA_WIDTH     = 32,
   parameter int unsigned SLAVE_N        = 0,
   parameter int          ORDER_FIFO_EXP = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_ack,
   input  logic                  cmd_rw,
   input  logic [1:0]            cmd_master,
   output logic                  order_full,
   input  logic                  slave_resp_valid,
   input  logic [DATA_WIDTH-1:0] slave_resp_data,
   output logic                  slave_resp_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [6:0]            resp_tag,
   input  logic                  resp_accept,
   output logic                  seq_err
);

   localparam int                  DEPTH    = 1 << ORDER_FIFO_EXP;
   localparam logic [1:0]          SLAVE_ID = SLAVE_N[1:0];
   localparam logic [ORDER_FIFO_EXP:0]   CNT_ONE  = (ORDER_FIFO_EXP+1)'(1);
   localparam logic [ORDER_FIFO_EXP:0]   CNT_FULL = (ORDER_FIFO_EXP+1)'(DEPTH);
   localparam logic [ORDER_FIFO_EXP-1:0] PTR_ONE  = ORDER_FIFO_EXP'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      PRESENT   = 2'd2
   } state_t;

   state_t                      state_reg;
   logic                        ack_d1_reg;
   logic [1:0]                  fifo_mem [DEPTH];
   logic [ORDER_FIFO_EXP-1:0]   wr_ptr_reg;
   logic [ORDER_FIFO_EXP-1:0]   rd_ptr_reg;
   logic [ORDER_FIFO_EXP:0]     count_reg;
   logic [ORDER_FIFO_EXP:0]     count_next;
   logic                        empty_reg;
   logic                        full_reg;
   logic                        push;
   logic                        pop;
   logic [1:0]                  head;
   logic [2:0]                  seq_reg [4];
   logic [3:0]                  seq_inc;
   logic                        resp_valid_reg;
   logic [DATA_WIDTH-1:0]       resp_data_reg;
   logic [6:0]                  resp_tag_reg;

   // Only the rising edge of a read ack records an entry; a held ack counts once.
   assign push = cmd_ack && !ack_d1_reg && !cmd_rw && !full_reg;
   assign pop  = (state_reg == PRESENT) && resp_accept;
   assign head = fifo_mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + CNT_ONE;
      else if (pop && !push)
         count_next = count_reg - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ack_d1_reg <= 1'b0;
      else
         ack_d1_reg <= cmd_ack;
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= cmd_master;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == CNT_FULL);
      end
   end

   assign order_full = full_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_seq_inc
         assign seq_inc[gi] = pop && (head == 2'(gi));
      end
   endgenerate

   // One counter per master: counts responses delivered from this slave, wraps at 8.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++)
            seq_reg[i] <= 3'd0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (seq_inc[i])
               seq_reg[i] <= seq_reg[i] + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
         resp_tag_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!empty_reg)
                  state_reg <= WAIT_DATA;
            end
            WAIT_DATA: begin
               if (slave_resp_valid) begin
                  resp_data_reg  <= slave_resp_data;
                  resp_tag_reg   <= {head, SLAVE_ID, seq_reg[head]};
                  resp_valid_reg <= 1'b1;
                  state_reg      <= PRESENT;
               end
            end
            PRESENT: begin
               if (resp_accept) begin
                  resp_valid_reg <= 1'b0;
                  state_reg      <= (count_next != '0) ? WAIT_DATA : IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign resp_valid = resp_valid_reg;
   assign resp_data  = resp_data_reg;
   assign resp_tag   = resp_tag_reg;

`ifdef SEQ_ORPHAN_CHECK_EN
   logic seq_err_reg;

   // With nothing outstanding, any slave response is an orphan: accept it so it cannot stall, and flag it.
   assign slave_resp_ready = (state_reg == WAIT_DATA) || ((state_reg == IDLE) && empty_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         seq_err_reg <= 1'b0;
      else if ((state_reg == IDLE) && empty_reg && slave_resp_valid)
         seq_err_reg <= 1'b1;
   end

   assign seq_err = seq_err_reg;
`else
   assign slave_resp_ready = (state_reg == WAIT_DATA);
   assign seq_err          = 1'b0;
`endif

endmodule

// File: tb/tb_slave_response_sequencer.sv
// Randomized bench for slave_response_sequencer (SLAVE_N=2): an in-order queue of masters plus per-master delivery counts predict every tag.
`timescale 1ns/1ps
module tb_slave_response_sequencer;

   localparam int DW = 32;
`ifdef SEQ_ORPHAN_CHECK_EN
   localparam bit ORPHAN = 1'b1;
`else
   localparam bit ORPHAN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_ack = 1'b0;
   logic          cmd_rw = 1'b0;
   logic [1:0]    cmd_master = 2'd0;
   logic          order_full;
   logic          slave_resp_valid = 1'b0;
   logic [DW-1:0] slave_resp_data = '0;
   logic          slave_resp_ready;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic [6:0]    resp_tag;
   logic          resp_accept = 1'b0;
   logic          seq_err;

   slave_response_sequencer #(
      .DATA_WIDTH    (DW),
      .SLAVE_N       (2),
      .ORDER_FIFO_EXP(3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_ack         (cmd_ack),
      .cmd_rw          (cmd_rw),
      .cmd_master      (cmd_master),
      .order_full      (order_full),
      .slave_resp_valid(slave_resp_valid),
      .slave_resp_data (slave_resp_data),
      .slave_resp_ready(slave_resp_ready),
      .resp_valid      (resp_valid),
      .resp_data       (resp_data),
      .resp_tag        (resp_tag),
      .resp_accept     (resp_accept),
      .seq_err         (seq_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: outstanding reads in issue order, responses delivered per master.
   int q[$];
   int dcount[4];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int m, input bit rw, input int hold);
      bit can_push;
      can_push = !rw && (q.size() < 8);
      cmd_master = 2'(m);
      cmd_rw     = rw;
      cmd_ack    = 1'b1;
      repeat (hold) tick();
      cmd_ack = 1'b0;
      cmd_rw  = 1'b0;
      if (can_push)
         q.push_back(m);
      tick();
      $display("issue  m=%0d rw=%0d hold=%0d depth=%0d", m, rw, hold, q.size());
      check("issue_full", order_full, q.size() == 8);
      check("issue_rv", resp_valid, 0);
   endtask

   task automatic deliver(input logic [DW-1:0] data, input bit push_en, input int push_m, input int hold);
      int t;
      int m;
      int etag;
      bit can_push;
      t = 0;
      while (!slave_resp_ready && t < 20) begin
         tick();
         t++;
      end
      if (!slave_resp_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      m    = q[0];
      etag = m * 32 + 2 * 8 + (dcount[m] % 8);
      slave_resp_valid = 1'b1;
      slave_resp_data  = data;
      tick();
      slave_resp_valid = 1'b0;
      $display("resp   m=%0d data=%08h tag=%07b exp=%07b", m, resp_data, resp_tag, 7'(etag));
      check("rv_set", resp_valid, 1);
      check("rdata", resp_data, data);
      check("rtag", resp_tag, etag);
      check("rdy_present", slave_resp_ready, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_rv", resp_valid, 1);
         check("hold_data", resp_data, data);
         check("hold_tag", resp_tag, etag);
      end
      can_push = push_en && (q.size() < 8);
      resp_accept = 1'b1;
      if (push_en) begin
         cmd_ack    = 1'b1;
         cmd_rw     = 1'b0;
         cmd_master = 2'(push_m);
      end
      tick();
      resp_accept = 1'b0;
      cmd_ack     = 1'b0;
      void'(q.pop_front());
      dcount[m]++;
      if (can_push)
         q.push_back(push_m);
      check("acc_rv", resp_valid, 0);
      check("acc_rdy", slave_resp_ready, (q.size() > 0) ? 1'b1 : ORPHAN);
      check("acc_full", order_full, q.size() == 8);
      if (push_en)
         tick();
   endtask

   task automatic drain();
      while (q.size() > 0)
         deliver($urandom, 1'b0, 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int depth;
      for (int i = 0; i < 4; i++) dcount[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rv", resp_valid, 0);
      check("rst_tag", resp_tag, 0);
      check("rst_full", order_full, 0);
      rst = 1'b1;
      repeat (5) tick();
      $display("reset  rv=%0d data=%0h tag=%0h rdy=%0d full=%0d err=%0d",
               resp_valid, resp_data, resp_tag, slave_resp_ready, order_full, seq_err);
      check("idle_rv", resp_valid, 0);
      check("idle_data", resp_data, 0);
      check("idle_tag", resp_tag, 0);
      check("idle_rdy", slave_resp_ready, ORPHAN);
      check("idle_full", order_full, 0);
      check("idle_err", seq_err, 0);

      // Single read from master 1, held unaccepted for 3 cycles.
      issue(1, 1'b0, 1);
      deliver(32'hA5A5A5A5, 1'b0, 0, 3);

      // Interleaved masters.
      issue(3, 1'b0, 1);
      issue(0, 1'b0, 1);
      issue(3, 1'b0, 1);
      drain();

      // Held ack pushes once; write ack pushes nothing.
      issue(2, 1'b0, 4);
      issue(1, 1'b1, 1);
      drain();
      repeat (3) tick();
      check("no_extra_rdy", slave_resp_ready, ORPHAN);
      check("no_extra_rv", resp_valid, 0);

      // Fill, drop a read while full, then pop and simultaneous push/pop.
      for (int i = 0; i < 8; i++) issue(int'($urandom_range(0, 3)), 1'b0, 1);
      issue(1, 1'b0, 1);
      deliver($urandom, 1'b0, 0, 0);
      depth = q.size();
      deliver($urandom, 1'b1, 2, 0);
      check("swap_depth", depth, q.size());
      issue(0, 1'b0, 1);
      drain();

      // Sequence wrap for master 2.
      for (int i = 0; i < 9; i++) begin
         issue(2, 1'b0, 1);
         deliver($urandom, 1'b0, 0, 0);
      end

      // Response with nothing outstanding.
      slave_resp_valid = 1'b1;
      slave_resp_data  = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("orph_rv", resp_valid, 0);
         check("orph_err", seq_err, ORPHAN);
      end
      slave_resp_valid = 1'b0;
      tick();
      issue(0, 1'b0, 1);
      deliver($urandom, 1'b0, 0, 0);
      check("orph_err_sticky", seq_err, ORPHAN);
      $display("orphan seq_err=%0d", seq_err);

      // Reset while a response is presented.
      issue(1, 1'b0, 1);
      issue(3, 1'b0, 1);
      slave_resp_valid = 1'b1;
      slave_resp_data  = 32'h12345678;
      tick();
      slave_resp_valid = 1'b0;
      check("pre_rst_rv", resp_valid, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_rv", resp_valid, 0);
      check("mid_rst_data", resp_data, 0);
      check("mid_rst_tag", resp_tag, 0);
      check("mid_rst_err", seq_err, 0);
      tick();
      rst = 1'b1;
      q.delete();
      for (int i = 0; i < 4; i++) dcount[i] = 0;
      repeat (3) tick();
      $display("reset2 rv=%0d rdy=%0d full=%0d", resp_valid, slave_resp_ready, order_full);
      check("post_rst_rdy", slave_resp_ready, ORPHAN);
      check("post_rst_full", order_full, 0);
      issue(3, 1'b0, 1);
      deliver($urandom, 1'b0, 0, 1);

      // Random mix of reads, writes, held acks, stalls and overlapping push/pop.
      for (int it = 0; it < 200; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (q.size() == 0 || (q.size() < 8 && r < 5))
            issue(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)));
         else
            deliver($urandom, 1'(($urandom_range(0, 1))), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
